// File: rtl/popcount_pattern_gen_pkg.sv
// popcount_pattern_gen_pkg
//   Shared definitions for the fixed-weight pattern generator tile:
//   controller state encoding, default geometry and the io_in pin map
//   of the 8-in/8-out tile wrapper.
package popcount_pattern_gen_pkg;

  localparam int WIDTH_DEF = 6;   // pattern width
  localparam int KW_DEF    = 3;   // width of the k field

  // io_in pin map
  localparam int CLK_BIT   = 0;
  localparam int RST_BIT   = 1;
  localparam int START_BIT = 2;
  localparam int ADV_BIT   = 3;
  localparam int K_LSB     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/popcount_pattern_gen_next_weight_word.sv
// next_weight_word
//   Purely combinational successor function for fixed-weight words: given a
//   word with k ones, produce the smallest numerically greater word with the
//   same number of ones, and flag whether that successor is the final word
//   (k ones packed into the MSBs).
// Ports:
//   word_i        current word (must not already be the final word)
//   k_i           number of ones in the sequence
//   next_o        successor word
//   next_is_top_o successor equals the final word for k_i
module next_weight_word
  import popcount_pattern_gen_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int KW    = KW_DEF
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] next_o,
  output logic             next_is_top_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL = '1;

  // Count of trailing zeros; a zero word yields WIDTH.
  function automatic int ctz(input logic [WIDTH-1:0] v);
    int n;
    n = WIDTH;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) n = i;
    end
    return n;
  endfunction

  logic [WIDTH-1:0] fill;     // trailing zeros of the word turned into ones
  logic [WIDTH-1:0] carry;    // lowest block of ones rippled up one place
  logic [WIDTH-1:0] refill;   // ones lost from that block, moved back to the LSBs
  logic [WIDTH-1:0] top_word;

  assign fill     = word_i | (word_i - ONE);
  assign carry    = fill + ONE;
  assign refill   = ((~fill & carry) - ONE) >> (ctz(word_i) + 1);
  assign next_o   = carry | refill;

  // Final word: k ones in the MSBs (all zeros when k is 0).
  assign top_word      = ~(ALL >> k_i);
  assign next_is_top_o = (next_o == top_word);

endmodule

// File: rtl/popcount_pattern_gen.sv
// popcount_pattern_gen
//   Enumerates every WIDTH-bit word with exactly k ones, in strictly
//   increasing order, one word per rising edge of advance. start loads k and
//   the first word; the sequence ends in DONE and never wraps. k > WIDTH
//   parks the tile in ERR.
// Ports:
//   io_in[0]        clock
//   io_in[1]        synchronous active-high reset
//   io_in[2]        start (level, highest priority after reset)
//   io_in[3]        advance (rising edge steps once)
//   io_in[4]        unused
//   io_in[7:5]      k, captured on start
//   out[WIDTH-1:0]  current pattern
//   out[WIDTH]      valid
//   out[WIDTH+1]    last
module popcount_pattern_gen
  import popcount_pattern_gen_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int KW    = KW_DEF
) (
  input  logic [7:0] io_in,
  output logic [7:0] out
);

  localparam logic [WIDTH-1:0] ALL = '1;

  logic          clk, rst, start, adv;
  logic [KW-1:0] k_in;
  logic          unused_io;

  assign clk       = io_in[CLK_BIT];
  assign rst       = io_in[RST_BIT];
  assign start     = io_in[START_BIT];
  assign adv       = io_in[ADV_BIT];
  assign k_in      = io_in[K_LSB +: KW];
  assign unused_io = io_in[4];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             adv_q;
  logic [KW-1:0]    k_q, k_d;

  // Word and last flag the next-state logic wants to present next cycle.
  logic [WIDTH-1:0] word_d;
  logic             at_top_d;

  logic             adv_evt;
  logic [WIDTH-1:0] first_word;
  logic             first_is_top;
  logic             k_too_big;
  logic [WIDTH-1:0] succ_word;
  logic             succ_is_top;

  assign adv_evt      = adv & ~adv_q;
  assign first_word   = ~(ALL << k_in);
  // The first word is also the final one only for k=0 and k=WIDTH.
  assign first_is_top = (k_in == '0) || (k_in == KW'(WIDTH));
  assign k_too_big    = (k_in > KW'(WIDTH));

  next_weight_word #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_next (
    .word_i        (pat_q),
    .k_i           (k_q),
    .next_o        (succ_word),
    .next_is_top_o (succ_is_top)
  );

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      adv_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      adv_q   <= adv;
      k_q     <= k_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and infers a latch.
    state_d  = state_q;
    word_d   = pat_q;
    k_d      = k_q;
    at_top_d = last_q;
    if (start) begin
      k_d = k_in;
      if (k_too_big) begin
        state_d  = ERR;
        at_top_d = 1'b0;
      end else begin
        state_d  = RUN;
        word_d   = first_word;
        at_top_d = first_is_top;
      end
    end else if (state_q == RUN && adv_evt) begin
      if (last_q) begin
        state_d = DONE;
      end else begin
        word_d   = succ_word;
        at_top_d = succ_is_top;
      end
    end
  end

  // Output logic (registered outputs, decoded from the next state)
  always_comb begin
    pat_d   = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    unique case (state_d)
      IDLE: ;
      RUN: begin
        pat_d   = word_d;
        valid_d = 1'b1;
        last_d  = at_top_d;
      end
      DONE: begin
        pat_d  = word_d;
        last_d = 1'b1;
      end
      ERR: pat_d = ALL;
      default: ;
    endcase
  end

  assign out = 8'({last_q, valid_q, pat_q});

  // Simulation-only invariants: every RUN word has weight k, and each
  // step strictly increases the word.
  a_weight : assert property (@(posedge clk) disable iff (rst)
    (state_q == RUN) |-> ($countones(pat_q) == int'(k_q)));

  a_increasing : assert property (@(posedge clk) disable iff (rst)
    (state_q == RUN && adv_evt && !start && !last_q) |=> (pat_q > $past(pat_q)));

endmodule
